// File: rtl/transpose_pkg.sv
// Shared definitions for the matrix-transpose datapath: element type and the
// XOR-diagonal switch-control helper used by the feeder and the downstream store.
package transpose_pkg;

    localparam int ELEM_W       = 64;
    localparam int MAX_SWITCHES = 64;

    typedef logic [ELEM_W-1:0] element_t;

    // Stage 'stage' swaps pairs differing in index bit (num_stages-1-stage), so its
    // switches all follow that bit of the row index.
    function automatic logic [MAX_SWITCHES-1:0] xor_ctrl(input logic [31:0] row,
                                                         input int          stage,
                                                         input int          num_stages);
        logic [4:0] idx;
        idx = 5'(num_stages - 1 - stage);
        return {MAX_SWITCHES{row[idx]}};
    endfunction

endpackage

// File: rtl/butterfly_feeder.sv
// Gathers LANES-wide beats into NUM_INPUTS-element rows, tags each row with its
// index and issues it with XOR-diagonal switch controls into the butterfly network.
module butterfly_feeder
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_INPUTS = 16,
    parameter int LANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_val,
    output logic                          s_rdy,
    input  logic [DATA_WIDTH-1:0]         s_data       [0:LANES-1],
    input  logic                          s_last,
    input  logic                          stall,
    output logic                          out_val,
    output logic [DATA_WIDTH-1:0]         out_elements [0:NUM_INPUTS-1],
    output logic [NUM_INPUTS/2-1:0]       out_ctrl     [0:$clog2(NUM_INPUTS)-1],
    output logic [$clog2(NUM_INPUTS)-1:0] out_row,
    output logic                          out_last
);

    localparam int NUM_STAGES   = $clog2(NUM_INPUTS);
    localparam int NUM_SWITCHES = NUM_INPUTS / 2;
    localparam int BEATS        = NUM_INPUTS / LANES;
    localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {FILL, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [NUM_STAGES-1:0]   row_cnt_q, row_cnt_d;
    logic                    last_pend_q, last_pend_d;
    logic [DATA_WIDTH-1:0]   buf_q [0:NUM_INPUTS-1];
    logic [DATA_WIDTH-1:0]   buf_d [0:NUM_INPUTS-1];
    logic [DATA_WIDTH-1:0]   row_w [0:NUM_INPUTS-1];

    logic                    out_val_q, out_val_d;
    logic                    out_last_q, out_last_d;
    logic [NUM_STAGES-1:0]   out_row_q, out_row_d;
    logic [DATA_WIDTH-1:0]   out_elements_q [0:NUM_INPUTS-1];
    logic [DATA_WIDTH-1:0]   out_elements_d [0:NUM_INPUTS-1];
    logic [NUM_SWITCHES-1:0] out_ctrl_q [0:NUM_STAGES-1];
    logic [NUM_SWITCHES-1:0] out_ctrl_d [0:NUM_STAGES-1];

    logic accept;
    logic row_done;
    logic issue;
    logic issue_last;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stall only matters once a row is complete
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: if (row_done && stall) state_d = HOLD;
            HOLD: if (!stall)            state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Output / control decode
    always_comb begin
        s_rdy      = (state_q == FILL) && !rst;
        accept     = s_val && s_rdy;
        row_done   = accept && ((beat_cnt_q == BEAT_W'(BEATS - 1)) || s_last);
        issue      = (state_q == FILL) ? (row_done && !stall) : !stall;
        issue_last = (state_q == HOLD) ? last_pend_q : s_last;
    end

    // Gather datapath: the current beat merged into the buffer forms the row
    always_comb begin
        for (int s = 0; s < NUM_INPUTS; s++) begin
            row_w[s] = buf_q[s];
            if (accept && ((s / LANES) == int'(beat_cnt_q))) begin
                row_w[s] = s_data[s % LANES];
            end
        end

        for (int s = 0; s < NUM_INPUTS; s++) begin
            buf_d[s] = issue ? '0 : row_w[s];
        end

        beat_cnt_d = beat_cnt_q;
        if (row_done) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        last_pend_d = last_pend_q;
        if (issue) begin
            last_pend_d = 1'b0;
        end else if (row_done) begin
            last_pend_d = s_last;
        end
    end

    // Issue registers; row payload and controls hold between pulses
    always_comb begin
        out_val_d      = issue;
        out_last_d     = issue && ((row_cnt_q == NUM_STAGES'(NUM_INPUTS - 1)) || issue_last);
        out_row_d      = out_row_q;
        out_elements_d = out_elements_q;
        out_ctrl_d     = out_ctrl_q;
        row_cnt_d      = row_cnt_q;
        if (issue) begin
            out_row_d      = row_cnt_q;
            out_elements_d = row_w;
            for (int i = 0; i < NUM_STAGES; i++) begin
                out_ctrl_d[i] = NUM_SWITCHES'(xor_ctrl(32'(row_cnt_q), i, NUM_STAGES));
            end
            row_cnt_d = out_last_d ? '0 : row_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q  <= '0;
            row_cnt_q   <= '0;
            last_pend_q <= 1'b0;
            out_val_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            for (int s = 0; s < NUM_INPUTS; s++) begin
                buf_q[s]          <= '0;
                out_elements_q[s] <= '0;
            end
            for (int i = 0; i < NUM_STAGES; i++) begin
                out_ctrl_q[i] <= '0;
            end
        end else begin
            beat_cnt_q     <= beat_cnt_d;
            row_cnt_q      <= row_cnt_d;
            last_pend_q    <= last_pend_d;
            out_val_q      <= out_val_d;
            out_last_q     <= out_last_d;
            out_row_q      <= out_row_d;
            buf_q          <= buf_d;
            out_elements_q <= out_elements_d;
            out_ctrl_q     <= out_ctrl_d;
        end
    end

    assign out_val      = out_val_q;
    assign out_last     = out_last_q;
    assign out_row      = out_row_q;
    assign out_elements = out_elements_q;
    assign out_ctrl     = out_ctrl_q;

endmodule

// File: tb/tb_butterfly_feeder.sv
// Directed bench for butterfly_feeder: streaming, stall/hold, early s_last and
// mid-row reset, plus a butterfly network model driven by the issued controls.
module tb_butterfly_feeder;

    localparam int DW = 64;
    localparam int N  = 16;
    localparam int L  = 4;
    localparam int ST = 4;
    localparam int SW = 8;

    logic          clk;
    logic          rst;
    logic          s_val;
    logic          s_rdy;
    logic [DW-1:0] s_data [0:L-1];
    logic          s_last;
    logic          stall;
    logic          out_val;
    logic [DW-1:0] out_elements [0:N-1];
    logic [SW-1:0] out_ctrl [0:ST-1];
    logic [ST-1:0] out_row;
    logic          out_last;

    int n_checks = 0;
    int n_err    = 0;

    butterfly_feeder #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .LANES(L)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_val        (s_val),
        .s_rdy        (s_rdy),
        .s_data       (s_data),
        .s_last       (s_last),
        .stall        (stall),
        .out_val      (out_val),
        .out_elements (out_elements),
        .out_ctrl     (out_ctrl),
        .out_row      (out_row),
        .out_last     (out_last)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: one beat, slot k of the beat carries base+k
    task automatic send(input logic [63:0] base, input logic last);
        s_val  = 1'b1;
        s_last = last;
        for (int k = 0; k < L; k++) s_data[k] = base + 64'(k);
        tick();
        s_val  = 1'b0;
        s_last = 1'b0;
    endtask

    // Expected row: slot j holds v0+j for j < filled, else zero; row index r
    task automatic check_row(input string tag, input int r, input logic exp_last,
                             input logic [63:0] v0, input int filled);
        logic [ST-1:0] rr;
        logic [63:0]   exp_el [0:N-1];
        logic [63:0]   net [0:N-1];
        logic [63:0]   t;
        int            b;
        int            p;
        rr = ST'(r);
        for (int j = 0; j < N; j++) exp_el[j] = (j < filled) ? v0 + 64'(j) : 64'd0;
        chk($sformatf("%s out_val", tag), 64'(out_val), 64'd1);
        chk($sformatf("%s out_row", tag), 64'(out_row), 64'(r));
        chk($sformatf("%s out_last", tag), 64'(out_last), 64'(exp_last));
        for (int j = 0; j < N; j++)
            chk($sformatf("%s elem%0d", tag, j), out_elements[j], exp_el[j]);
        for (int i = 0; i < ST; i++)
            chk($sformatf("%s ctrl%0d", tag, i), 64'(out_ctrl[i]), rr[ST-1-i] ? 64'hFF : 64'h0);
        // Butterfly model: stage i swaps lanes differing in bit ST-1-i
        for (int j = 0; j < N; j++) net[j] = out_elements[j];
        for (int i = 0; i < ST; i++) begin
            b = ST - 1 - i;
            if (out_ctrl[i][0]) begin
                for (int j = 0; j < N; j++) begin
                    if (((j >> b) & 1) == 0) begin
                        p      = j | (1 << b);
                        t      = net[j];
                        net[j] = net[p];
                        net[p] = t;
                    end
                end
            end
        end
        for (int j = 0; j < N; j++)
            chk($sformatf("%s net%0d", tag, j), net[j], exp_el[j ^ r]);
    endtask

    // Full row of four back-to-back beats, values v0..v0+15
    task automatic send_row(input logic [63:0] v0, input int r, input logic last_in,
                            input logic exp_last);
        for (int b = 0; b < 4; b++) begin
            send(v0 + 64'(4 * b), (b == 3) && last_in);
            if (b < 3) chk($sformatf("row%0d beat%0d idle", r, b), 64'(out_val), 64'd0);
            else       check_row($sformatf("row%0d", r), r, exp_last, v0, N);
        end
    endtask

    initial begin
        rst    = 1'b1;
        s_val  = 1'b0;
        s_last = 1'b0;
        stall  = 1'b0;
        for (int k = 0; k < L; k++) s_data[k] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_val", 64'(out_val), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst out_row", 64'(out_row), 64'd0);
        chk("rst s_rdy", 64'(s_rdy), 64'd0);
        chk("rst elem0", out_elements[0], 64'd0);
        chk("rst elem15", out_elements[15], 64'd0);
        chk("rst ctrl0", 64'(out_ctrl[0]), 64'd0);
        chk("rst ctrl3", 64'(out_ctrl[3]), 64'd0);
        rst = 1'b0;
        #1;
        chk("post-rst s_rdy", 64'(s_rdy), 64'd1);

        // Streaming: 64 back-to-back beats, row r slot j = r*16+j
        for (int r = 0; r < N; r++) send_row(64'(r * 16), r, 1'b0, r == N - 1);
        tick();
        chk("stream tail idle", 64'(out_val), 64'd0);
        chk("stream row hold", 64'(out_row), 64'd15);

        // Stall when row 2 completes, held 7 cycles
        send_row(64'd1000, 0, 1'b0, 1'b0);
        send_row(64'd1016, 1, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) send(64'd1032 + 64'(4 * b), 1'b0);
        stall = 1'b1;
        send(64'd1044, 1'b0);
        chk("stall out_val c0", 64'(out_val), 64'd0);
        chk("stall s_rdy c0", 64'(s_rdy), 64'd0);
        for (int c = 1; c < 7; c++) begin
            tick();
            chk($sformatf("stall out_val c%0d", c), 64'(out_val), 64'd0);
            chk($sformatf("stall s_rdy c%0d", c), 64'(s_rdy), 64'd0);
        end
        stall = 1'b0;
        tick();
        check_row("stall row2", 2, 1'b0, 64'd1032, N);
        chk("stall release s_rdy", 64'(s_rdy), 64'd1);
        tick();
        chk("stall single pulse", 64'(out_val), 64'd0);

        // s_last on the 4th beat of row 3
        send_row(64'd2000, 3, 1'b1, 1'b1);
        // Protocol-error partial row: s_last on the 2nd beat
        send(64'd3000, 1'b0);
        chk("partial beat0 idle", 64'(out_val), 64'd0);
        send(64'd3004, 1'b1);
        check_row("partial", 0, 1'b1, 64'd3000, 8);
        send_row(64'd4000, 0, 1'b0, 1'b0);

        // Reset after two beats of row 7
        for (int r = 1; r < 7; r++) send_row(64'd5000 + 64'(r * 16), r, 1'b0, 1'b0);
        send(64'd5112, 1'b0);
        send(64'd5116, 1'b0);
        chk("pre-rst idle", 64'(out_val), 64'd0);
        rst = 1'b1;
        #1;
        chk("midrst out_val", 64'(out_val), 64'd0);
        chk("midrst out_row", 64'(out_row), 64'd0);
        chk("midrst s_rdy", 64'(s_rdy), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst release s_rdy", 64'(s_rdy), 64'd1);
        tick();
        chk("midrst no issue", 64'(out_val), 64'd0);
        send(64'd6000, 1'b1);
        check_row("after rst partial", 0, 1'b1, 64'd6000, L);
        send_row(64'd7000, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
